// File: rtl/arch_map_table_param.sv
// Architectural map table: committed logical->physical map with coalesced multi-lane commit,
// displaced-tag release, and a beat-by-beat recovery walk toward the rename map table.
module arch_map_table_param #(
    parameter  int NUM_LOG  = 32,
    parameter  int PHY_W    = 7,
    parameter  int COMMIT_W = 4,
    parameter  int RCV_W    = 4,
    localparam int LOG_W    = $clog2(NUM_LOG),
    localparam int NBEAT    = (NUM_LOG + RCV_W - 1) / RCV_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [COMMIT_W-1:0]       commit_valid_i,
    input  logic [COMMIT_W*LOG_W-1:0] commit_log_i,
    input  logic [COMMIT_W*PHY_W-1:0] commit_phy_i,
    output logic [COMMIT_W-1:0]       rel_valid_o,
    output logic [COMMIT_W*PHY_W-1:0] rel_phy_o,
    input  logic                      recover_start_i,
    output logic                      recover_busy_o,
    output logic                      recover_done_o,
    output logic [RCV_W-1:0]          rcv_valid_o,
    output logic [RCV_W*LOG_W-1:0]    rcv_log_o,
    output logic [RCV_W*PHY_W-1:0]    rcv_phy_o
);

    localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int IDX_W = LOG_W + 1;

    typedef enum logic {
        IDLE,
        RECOVER
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nextCnt;

    logic [PHY_W-1:0] mapTable [NUM_LOG];
    logic [COMMIT_W-1:0] laneWrite;
    logic [LOG_W-1:0]    laneLog;
    logic [IDX_W-1:0]    beatIdx;

    // Coalescing: a lane is suppressed when any younger valid lane targets the same entry;
    // a suppressed lane's own new tag is dead on arrival and goes straight back to the free list.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        laneWrite   = '0;
        laneLog     = '0;
        rel_valid_o = '0;
        rel_phy_o   = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            laneLog      = commit_log_i[k*LOG_W +: LOG_W];
            laneWrite[k] = commit_valid_i[k];
            for (int m = k + 1; m < COMMIT_W; m++) begin
                if (commit_valid_i[m] && (commit_log_i[m*LOG_W +: LOG_W] == laneLog)) begin
                    laneWrite[k] = 1'b0;
                end
            end
            if (commit_valid_i[k]) begin
                rel_valid_o[k] = 1'b1;
                if (!laneWrite[k]) begin
                    rel_phy_o[k*PHY_W +: PHY_W] = commit_phy_i[k*PHY_W +: PHY_W];
                end else if (int'(laneLog) < NUM_LOG) begin
                    rel_phy_o[k*PHY_W +: PHY_W] = mapTable[laneLog];
                end
            end
        end
    end

    // NOTE: the table is reset because the identity map is architectural state, not scratch data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOG; i++) begin
                mapTable[i] <= PHY_W'(i);
            end
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (laneWrite[k] && (int'(commit_log_i[k*LOG_W +: LOG_W]) < NUM_LOG)) begin
                    mapTable[commit_log_i[k*LOG_W +: LOG_W]] <= commit_phy_i[k*PHY_W +: PHY_W];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        case (state)
            IDLE: begin
                if (recover_start_i) begin
                    nextState = RECOVER;
                    nextCnt   = '0;
                end
            end
            RECOVER: begin
                if (int'(cnt) == NBEAT - 1) begin
                    nextState = IDLE;
                    nextCnt   = '0;
                end else begin
                    nextCnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                nextState = IDLE;
                nextCnt   = '0;
            end
        endcase
    end

    // Beat lanes past the end of the table (partial tail beat) are flagged invalid and zeroed.
    always_comb begin
        recover_busy_o = (state == RECOVER);
        recover_done_o = 1'b0;
        rcv_valid_o    = '0;
        rcv_log_o      = '0;
        rcv_phy_o      = '0;
        beatIdx        = '0;
        if (state == RECOVER) begin
            recover_done_o = (int'(cnt) == NBEAT - 1);
            for (int j = 0; j < RCV_W; j++) begin
                beatIdx = IDX_W'(int'(cnt) * RCV_W + j);
                if (int'(beatIdx) < NUM_LOG) begin
                    rcv_valid_o[j]              = 1'b1;
                    rcv_log_o[j*LOG_W +: LOG_W] = beatIdx[LOG_W-1:0];
                    rcv_phy_o[j*PHY_W +: PHY_W] = mapTable[beatIdx[LOG_W-1:0]];
                end
            end
        end
    end

endmodule

// File: tb/tb_arch_map_table_param.sv
// Scoreboard bench for arch_map_table_param: a 32-entry instance carries the commit traffic,
// a 30-entry instance walks alongside to exercise the partial tail beat.
module tb_arch_map_table_param;

    localparam int NBEAT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  commitValid = '0;
    logic [19:0] commitLog = '0;
    logic [27:0] commitPhy = '0;
    logic        recoverStart = 1'b0;

    logic [3:0]  relValid, relValid30;
    logic [27:0] relPhy, relPhy30;
    logic        busy, busy30, done, done30;
    logic [3:0]  rcvValid, rcvValid30;
    logic [19:0] rcvLog, rcvLog30;
    logic [27:0] rcvPhy, rcvPhy30;

    arch_map_table_param #(.NUM_LOG(32), .PHY_W(7), .COMMIT_W(4), .RCV_W(4)) dut (
        .clk(clk), .reset(reset),
        .commit_valid_i(commitValid), .commit_log_i(commitLog), .commit_phy_i(commitPhy),
        .rel_valid_o(relValid), .rel_phy_o(relPhy),
        .recover_start_i(recoverStart), .recover_busy_o(busy), .recover_done_o(done),
        .rcv_valid_o(rcvValid), .rcv_log_o(rcvLog), .rcv_phy_o(rcvPhy)
    );

    arch_map_table_param #(.NUM_LOG(30), .PHY_W(7), .COMMIT_W(4), .RCV_W(4)) dut30 (
        .clk(clk), .reset(reset),
        .commit_valid_i('0), .commit_log_i('0), .commit_phy_i('0),
        .rel_valid_o(relValid30), .rel_phy_o(relPhy30),
        .recover_start_i(recoverStart), .recover_busy_o(busy30), .recover_done_o(done30),
        .rcv_valid_o(rcvValid30), .rcv_log_o(rcvLog30), .rcv_phy_o(rcvPhy30)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  v;
        logic [19:0] l;
        logic [27:0] p;
        logic        d;
    } beat_t;

    typedef struct packed {
        logic [3:0]  v;
        logic [27:0] p;
    } rel_t;

    beat_t beatQ[$];
    beat_t beatQ30[$];
    rel_t  relQ[$];
    logic [6:0] model [32];
    int testsRun = 0;
    int testsFailed = 0;
    int beatsSeen = 0;
    int beatsSeen30 = 0;
    bit walkActive = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mkBeat(int b, int nlog, bit useModel);
        beat_t r;
        r = '0;
        r.d = (b == NBEAT - 1);
        for (int j = 0; j < 4; j++) begin
            int idx = b * 4 + j;
            if (idx < nlog) begin
                r.v[j] = 1'b1;
                r.l[j*5 +: 5] = idx[4:0];
                r.p[j*7 +: 7] = useModel ? model[idx] : idx[6:0];
            end
        end
        return r;
    endfunction

    task automatic modelIdentity();
        for (int i = 0; i < 32; i++) model[i] = i[6:0];
    endtask

    task automatic pushWalk();
        for (int b = 0; b < NBEAT; b++) begin
            beatQ.push_back(mkBeat(b, 32, 1'b1));
            beatQ30.push_back(mkBeat(b, 30, 1'b0));
        end
        walkActive = 1'b1;
    endtask

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cycle(input logic [3:0] v, input logic [19:0] l, input logic [27:0] p, input bit st);
        rel_t e;
        bit   sup;
        commitValid  = v;
        commitLog    = l;
        commitPhy    = p;
        recoverStart = st;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
                sup = 1'b0;
                for (int m = k + 1; m < 4; m++)
                    if (v[m] && l[m*5 +: 5] == l[k*5 +: 5]) sup = 1'b1;
                e.v[k] = 1'b1;
                e.p[k*7 +: 7] = sup ? p[k*7 +: 7] : model[l[k*5 +: 5]];
            end
        end
        relQ.push_back(e);
        #3;
        e = relQ.pop_front();
        check("rel_valid", {60'd0, relValid}, {60'd0, e.v});
        check("rel_phy", {36'd0, relPhy}, {36'd0, e.p});
        @(posedge clk);
        // Oldest-to-youngest overwrite leaves the youngest lane's tag in each entry.
        for (int k = 0; k < 4; k++)
            if (v[k]) model[l[k*5 +: 5]] = p[k*7 +: 7];
        if (st && !walkActive) pushWalk();
        #1;
        commitValid  = '0;
        commitLog    = '0;
        commitPhy    = '0;
        recoverStart = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0, 20'd0, 28'd0, 1'b0);
    endtask

    task automatic waitWalk();
        int g = 0;
        while ((walkActive || beatQ.size() != 0 || beatQ30.size() != 0) && g < 40) begin
            cycle(4'b0, 20'd0, 28'd0, 1'b0);
            g++;
        end
        if (g >= 40) check("walk_timeout", 64'd1, 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        beat_t b;
        beat_t b30;
        if (!reset) begin
            if (busy) begin
                if (beatQ.size() == 0) begin
                    check("unexpected_beat", {63'd0, busy}, 64'd0);
                end else begin
                    b = beatQ.pop_front();
                    check("rcv_valid", {60'd0, rcvValid}, {60'd0, b.v});
                    check("rcv_log", {44'd0, rcvLog}, {44'd0, b.l});
                    check("rcv_phy", {36'd0, rcvPhy}, {36'd0, b.p});
                    check("rcv_done", {63'd0, done}, {63'd0, b.d});
                    beatsSeen++;
                    if (b.d) walkActive = 1'b0;
                end
            end else begin
                check("idle_done", {63'd0, done}, 64'd0);
                check("idle_rcv_valid", {60'd0, rcvValid}, 64'd0);
                check("idle_rcv_phy", {36'd0, rcvPhy}, 64'd0);
            end
            if (busy30) begin
                if (beatQ30.size() == 0) begin
                    check("unexpected_beat30", {63'd0, busy30}, 64'd0);
                end else begin
                    b30 = beatQ30.pop_front();
                    check("rcv_valid30", {60'd0, rcvValid30}, {60'd0, b30.v});
                    check("rcv_log30", {44'd0, rcvLog30}, {44'd0, b30.l});
                    check("rcv_phy30", {36'd0, rcvPhy30}, {36'd0, b30.p});
                    check("rcv_done30", {63'd0, done30}, {63'd0, b30.d});
                    beatsSeen30++;
                end
            end else begin
                check("idle_done30", {63'd0, done30}, 64'd0);
                check("idle_rcv_valid30", {60'd0, rcvValid30}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        int g;
        logic [19:0] rl;
        logic [27:0] rp;
        modelIdentity();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_rcv_valid", {60'd0, rcvValid}, 64'd0);
        check("reset_rcv_log", {44'd0, rcvLog}, 64'd0);
        check("reset_rel_valid", {60'd0, relValid}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // Single commit, then same-entry collision across three lanes.
        cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {7'd0, 7'd0, 7'd0, 7'd40}, 1'b0);
        cycle(4'b0111, {5'd0, 5'd5, 5'd5, 5'd5}, {7'd0, 7'd52, 7'd51, 7'd50}, 1'b0);

        // Full walk on both instances.
        base = beatsSeen;
        cycle(4'b0, 20'd0, 28'd0, 1'b1);
        waitWalk();
        check("walk_beats", 64'(beatsSeen - base), 64'd8);

        // Random commit traffic with frequent collisions, then verify the table by walking.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 4; k++) begin
                rl[k*5 +: 5] = 5'($urandom_range(0, 7));
                rp[k*7 +: 7] = 7'($urandom);
            end
            cycle(4'($urandom_range(0, 15)), rl, rp, 1'b0);
        end
        cycle(4'b0, 20'd0, 28'd0, 1'b1);
        waitWalk();

        // Second start at beat 2 must be ignored.
        base = beatsSeen;
        cycle(4'b0, 20'd0, 28'd0, 1'b1);
        idle(2);
        cycle(4'b0, 20'd0, 28'd0, 1'b1);
        waitWalk();
        idle(3);
        check("restart_ignored_beats", 64'(beatsSeen - base), 64'd8);

        // Reset at beat 3 aborts the walk and restores identity.
        base = beatsSeen;
        cycle(4'b1000, {5'd9, 15'd0}, {7'd77, 21'd0}, 1'b0);
        cycle(4'b0, 20'd0, 28'd0, 1'b1);
        g = 0;
        while (beatsSeen < base + 3 && g < 20) begin
            idle(1);
            g++;
        end
        if (g >= 20) check("beat3_timeout", 64'd1, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        beatQ.delete();
        beatQ30.delete();
        walkActive = 1'b0;
        modelIdentity();
        @(negedge clk);
        check("reset_abort_busy", {63'd0, busy}, 64'd0);
        check("reset_abort_busy30", {63'd0, busy30}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        base = beatsSeen;
        cycle(4'b0, 20'd0, 28'd0, 1'b1);
        waitWalk();
        check("post_reset_walk_beats", 64'(beatsSeen - base), 64'd8);

        // Commit in the same cycle as start is visible from beat 0 onward.
        cycle(4'b0001, {15'd0, 5'd7}, {21'd0, 7'd99}, 1'b1);
        waitWalk();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
